master_bus_port: RTL

Master-side bus port that sits directly upstream of the bus arbiter (`controller_top`) in the serial bus. It accepts one transaction from a local master core, raises that master's request bit toward the arbiter, and waits for the matching grant bit. Once granted, it serialises a header and, for a write, the data onto the shared bus; for a read, it deserialises the slave's response. It then releases the bus, so one instance exists per master (12 in the system).

---
 rtl/master_bus_port.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/master_bus_port.sv
// master_bus_port: one master's port onto the shared serial bus.
// Requests the bus, shifts out a header and write data MSB first,
// and collects read data.
// Ports: clk, rst (async, active-high); core side start/rw/slave_id/
// mem_addr/wdata in and rdata/busy/done/error out; arbiter side
// bus_req out, bus_grant in; bus side tx_bit/tx_valid out and
// slave_ack/rx_bit/rx_valid in.
module master_bus_port #(
    parameter int SLV_W       = 2,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [SLV_W-1:0]  slave_id,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              tx_bit,
    output logic              tx_valid,
    input  logic              slave_ack,
    input  logic              rx_bit,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int         HDR_W     = SLV_W + 1 + ADDR_W;
    localparam logic [3:0] HDR_LAST  = 4'(HDR_W - 1);
    localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
    // Abort is taken on the edge that ends the ACK_TIMEOUT-th idle cycle.
    localparam logic [7:0] TMO_LAST  = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, HDR, WAIT_ACK, WDATA, RDATA, FIN, ABORT
    } state_t;

    state_t            state, state_nxt;
    logic [HDR_W-1:0]  hdr_sr;
    logic [DATA_W-1:0] wd_sr;
    logic              rw_q;
    logic [3:0]        bit_cnt;
    logic [7:0]        tmo_cnt;
    logic              tmo_hit;

    assign tmo_hit = (tmo_cnt >= TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grant loss beats everything; ack/rx_valid beat timeout expiry.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = REQ;
            REQ:      if (bus_grant) state_nxt = HDR;
            HDR: begin
                if (!bus_grant)              state_nxt = ABORT;
                else if (bit_cnt == HDR_LAST) state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!bus_grant)     state_nxt = ABORT;
                else if (slave_ack) state_nxt = rw_q ? WDATA : RDATA;
                else if (tmo_hit)   state_nxt = ABORT;
            end
            WDATA: begin
                if (!bus_grant)                state_nxt = ABORT;
                else if (bit_cnt == DATA_LAST) state_nxt = FIN;
            end
            RDATA: begin
                if (!bus_grant) state_nxt = ABORT;
                else if (rx_valid) begin
                    if (bit_cnt == DATA_LAST) state_nxt = FIN;
                end
                else if (tmo_hit) state_nxt = ABORT;
            end
            FIN:      state_nxt = IDLE;
            ABORT:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from state so reset clears them at once.
    always_comb begin
        bus_req  = (state == REQ) || (state == HDR) ||
                   (state == WAIT_ACK) || (state == WDATA) ||
                   (state == RDATA);
        tx_valid = ((state == HDR) || (state == WDATA)) && bus_grant;
        tx_bit   = tx_valid &&
                   ((state == HDR) ? hdr_sr[HDR_W-1] : wd_sr[DATA_W-1]);
        busy     = (state != IDLE);
        done     = (state == FIN);
        error    = (state == ABORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_sr  <= '0;
            wd_sr   <= '0;
            rw_q    <= 1'b0;
            bit_cnt <= '0;
            tmo_cnt <= '0;
            rdata   <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    rw_q    <= rw;
                    hdr_sr  <= {slave_id, rw, mem_addr};
                    wd_sr   <= wdata;
                    bit_cnt <= '0;
                    tmo_cnt <= '0;
                end
                HDR: if (bus_grant) begin
                    hdr_sr  <= hdr_sr << 1;
                    bit_cnt <= (bit_cnt == HDR_LAST) ? 4'd0
                                                     : bit_cnt + 4'd1;
                    tmo_cnt <= '0;
                end
                WAIT_ACK: begin
                    if (slave_ack)             tmo_cnt <= '0;
                    else if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
                end
                WDATA: if (bus_grant) begin
                    wd_sr   <= wd_sr << 1;
                    bit_cnt <= bit_cnt + 4'd1;
                end
                RDATA: begin
                    if (bus_grant && rx_valid) begin
                        rdata   <= {rdata[DATA_W-2:0], rx_bit};
                        bit_cnt <= bit_cnt + 4'd1;
                        tmo_cnt <= '0;
                    end else if (tmo_cnt != 8'hFF) begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
